// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: RISC-V M funct3 codes,
// sequencer states and operand-signedness helpers.
package muldiv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      MULDIV_OP_MUL    = 3'b000,
      MULDIV_OP_MULH   = 3'b001,
      MULDIV_OP_MULHSU = 3'b010,
      MULDIV_OP_MULHU  = 3'b011,
      MULDIV_OP_DIV    = 3'b100,
      MULDIV_OP_DIVU   = 3'b101,
      MULDIV_OP_REM    = 3'b110,
      MULDIV_OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic op_signed_a(input logic [2:0] op);
      return (op != MULDIV_OP_MULHU) && (op != MULDIV_OP_DIVU) && (op != MULDIV_OP_REMU);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == MULDIV_OP_MUL) || (op == MULDIV_OP_MULH) ||
             (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiply (LSB first) and restoring divide (MSB first),
// one bit per step on unsigned magnitudes.
module muldiv_iter_dp #(
   parameter int unsigned W = muldiv_pkg::XLEN
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic           step,
   input  logic           op_is_div,
   input  logic [W-1:0]   opa,
   input  logic [W-1:0]   opb,
   output logic [2*W-1:0] prod_nxt,
   output logic [W-1:0]   quot_nxt,
   output logic [W-1:0]   rem_nxt
);
   import muldiv_pkg::*;

   logic [2*W-1:0] prod_q;
   logic [W-1:0]   quot_q;
   logic [W-1:0]   rem_q;
   logic [W-1:0]   opnd_q;   // multiplicand for mul, divisor for div
   logic [W:0]     add_sum;
   logic [W:0]     rem_shift;
   logic           rem_ge;

   always_comb begin
      // Upper half accumulates, lower half holds the unconsumed multiplier bits
      add_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      prod_nxt  = {add_sum, prod_q[W-1:1]};
      rem_shift = {rem_q, quot_q[W-1]};
      rem_ge    = rem_shift >= {1'b0, opnd_q};
      rem_nxt   = rem_ge ? W'(rem_shift - {1'b0, opnd_q}) : rem_shift[W-1:0];
      quot_nxt  = {quot_q[W-2:0], rem_ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         opnd_q <= '0;
      end else if (init) begin
         prod_q <= {{W{1'b0}}, opb};
         quot_q <= opa;
         rem_q  <= '0;
         opnd_q <= op_is_div ? opb : opa;
      end else if (step) begin
         if (op_is_div) begin
            quot_q <= quot_nxt;
            rem_q  <= rem_nxt;
         end else begin
            prod_q <= prod_nxt;
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage multi-cycle M-extension sequencer: accepts one op, stalls the front end while
// iterating, then pulses done with the registered, sign-corrected result.
module ex_muldiv_seq #(
   parameter int unsigned XLEN         = muldiv_pkg::XLEN,
   parameter int unsigned CNT_W        = 5,
   parameter int unsigned LATENCY_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   import muldiv_pkg::*;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sign_a, sign_b, neg_in;
   logic              div_by_zero, div_ovf;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              dp_init, dp_step, dp_is_div;
   logic [2*XLEN-1:0] prod_nxt, prod_fix;
   logic [XLEN-1:0]   quot_nxt, rem_nxt, qr_sel, run_result;

   assign sign_a = op_signed_a(op) & rs1_data[XLEN-1];
   assign sign_b = op_signed_b(op) & rs2_data[XLEN-1];
   assign abs_a  = sign_a ? -rs1_data : rs1_data;
   assign abs_b  = sign_b ? -rs2_data : rs2_data;
   // Remainder takes the dividend's sign; every other signed op takes the product sign
   assign neg_in = (op == MULDIV_OP_REM) ? sign_a : (sign_a ^ sign_b);

   assign div_by_zero = op[2] & (rs2_data == '0);
   assign div_ovf     = op[2] & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &
                        (rs2_data == '1);

   assign dp_is_div = dp_init ? op[2] : op_q[2];

   muldiv_iter_dp #(
      .W (XLEN)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .init      (dp_init),
      .step      (dp_step),
      .op_is_div (dp_is_div),
      .opa       (abs_a),
      .opb       (abs_b),
      .prod_nxt  (prod_nxt),
      .quot_nxt  (quot_nxt),
      .rem_nxt   (rem_nxt)
   );

   // Final-iteration values feed the result register directly so it is valid in DONE
   always_comb begin
      prod_fix = neg_q ? -prod_nxt : prod_nxt;
      qr_sel   = op_q[1] ? rem_nxt : quot_nxt;
      if (neg_q) begin
         qr_sel = -qr_sel;
      end
      case (op_q)
         MULDIV_OP_MUL:                                     run_result = prod_fix[XLEN-1:0];
         MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: run_result = prod_fix[2*XLEN-1:XLEN];
         default:                                           run_result = qr_sel;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      done_d   = 1'b0;
      result_d = result_q;
      dp_init  = 1'b0;
      dp_step  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_d  = op;
                  neg_d = neg_in;
                  cnt_d = '0;
                  if (div_by_zero) begin
                     state_d  = S_DONE;
                     done_d   = 1'b1;
                     result_d = op[1] ? rs1_data : '1;
                  end else if (div_ovf) begin
                     state_d  = S_DONE;
                     done_d   = 1'b1;
                     result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  end else begin
                     state_d = S_RUN;
                     dp_init = 1'b1;
                  end
               end
            end
            S_RUN: begin
               dp_step = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(LATENCY_ITER - 1)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = run_result;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign stall  = ~flush & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer attached to the EX stage.
- Accepts one M-extension operation from ID/EX, using operands already resolved by EX forwarding.
- Runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Holds EX_stall-style `stall` until the result is ready; pulses `done` for the cycle in which the EX/MEM register captures `result`.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).
- LATENCY_ITER, 32, iterations per normal operation; fixed at XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  ID/EX holds a valid mul/div op; level, held stable while stall=1
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  32  forwarded operand 1 (dividend/multiplicand)
- rs2_data  in  32  forwarded operand 2 (divisor/multiplier)
- flush  in  1  branch/jump flush of the EX stage; aborts any operation
- stall  out  1  freeze PC, IF/ID, ID/EX; combinational
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  32  registered result, valid while done=1

Behaviour:
- Reset: state=IDLE, cnt=0, done=0, result=0, busy=0, internal acc/quot/rem/neg flags=0. stall=0 unless start=1 (it is combinational).
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0:
  - Latch op and the absolute values of the operands. Signed ops: DIV/REM/MULH take abs of both operands; MULHSU takes abs of rs1 only.
  - Latch the result sign: MUL/MULH = sign1^sign2; MULHSU = sign1; DIV = sign1^sign2; REM = sign1.
  - Go to RUN with cnt=0.
- IDLE special cases (go straight to DONE):
  - Divide by zero (op[2]=1, rs2=0): quotient=0xFFFFFFFF, remainder=rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Latency for these cases: done in cycle 1.
- RUN, multiply: 64-bit product register, shift-add one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division on a 33-bit partial remainder; one quotient bit per cycle, MSB first.
- RUN: cnt increments each cycle; after the iteration with cnt=31, go to DONE.
- DONE:
  - Apply sign correction (two's complement negate if the neg flag is set).
  - Select the result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the result so it is valid in the DONE cycle. done=1.
  - Next state is IDLE unconditionally.
- Latency: start accepted at end of cycle 0 → RUN in cycles 1..32 → DONE (done=1) in cycle 33.
- stall = (state==IDLE & start & !flush) | state==RUN. stall=0 in DONE so the pipeline advances and captures the result.
- start is ignored in DONE: it is the same instruction, still in ID/EX. A new start is accepted only in IDLE, so the earliest next acceptance is cycle 34.
- flush has priority over start and over all states: next state is IDLE, done stays 0, result keeps its old value, stall drops the same cycle.
- rst mid-operation: same as reset values at the next edge; no done pulse.
- Operands and op are ignored after acceptance; changes on rs1_data/rs2_data during RUN have no effect.
- done is never asserted in two consecutive cycles.

Decomposition:
- Shared package `muldiv_pkg`: op encodings (MULDIV_OP_* by funct3), state encoding (S_IDLE, S_RUN, S_DONE), XLEN.
- One natural sub-module, `muldiv_iter_dp`: datapath holding the product/remainder/quotient registers and the per-cycle add/subtract-shift step. It is controlled by init/step/op_is_div signals.
- The FSM, counter, special-case detection and sign fixup stay in ex_muldiv_seq.

Test Plan:
- MUL 7×(−3): rs1=7, rs2=0xFFFFFFFD, op=000 → stall high cycles 0..32, done in cycle 33 with result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF (op=011) → result=0xFFFFFFFE. MULH same operands (op=001) → result=0x00000000.
- DIV −7/2 (op=100) → result=0xFFFFFFFD. REM −7/2 (op=110) → result=0xFFFFFFFF. DIVU 100/7 (op=101) → result=14.
- Divide by zero: DIVU 5/0 → result=0xFFFFFFFF, done in cycle 1. REM 5/0 → result=5. Overflow case: DIV 0x80000000/−1 → result=0x80000000, REM → 0, both done in cycle 1.
- flush asserted in cycle 10 of a DIV → busy=0 and stall=0 from cycle 11, no done pulse. A new MUL 3×4 started in cycle 11 → done in cycle 44 with result=12.
- start held through DONE then kept high one more cycle (back-to-back ops) → exactly one done per accepted op. rst asserted in cycle 5 of a MUL → done=0, result=0, state IDLE at cycle 6.
